// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// Core has priority; aux wins one cycle after STARVE_MAX denials.
module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic [3:0]        core_we,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              aux_req,
    input  logic [3:0]        aux_we,
    input  logic [31:0]       aux_addr,
    input  logic [31:0]       aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [31:0]       aux_rdata,
    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    input  logic [31:0]       dmem_dout
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt;
    logic        aux_prio;
    logic        any_gnt;
    logic        sel_oor;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        core_oor;
    logic        aux_oor;
    logic        unused_addr_lsb;

    // {pend_core, pend_aux, pend_oor}
    logic [2:0] pend_q;
    logic [2:0] pend_d;

    assign unused_addr_lsb = ^{core_addr[1:0], aux_addr[1:0]};

    assign core_oor = |core_addr[31:ADDR_W+2];
    assign aux_oor  = |aux_addr[31:ADDR_W+2];

    // Grants are gated by reset so nothing reaches DMEM while held in reset.
    always_comb begin
        aux_prio   = (starve_cnt == STARVE_LIM);
        core_gnt   = reset & core_req & ~(aux_req & aux_prio);
        aux_gnt    = reset & aux_req & (~core_req | aux_prio);
        any_gnt    = core_gnt | aux_gnt;
        core_stall = reset & core_req & ~core_gnt;
    end

    always_comb begin
        sel_we    = aux_gnt ? aux_we    : core_we;
        sel_addr  = aux_gnt ? aux_addr  : core_addr;
        sel_wdata = aux_gnt ? aux_wdata : core_wdata;
        sel_oor   = aux_gnt ? aux_oor   : core_oor;
        dmem_en   = any_gnt & ~sel_oor;
        dmem_we   = dmem_en ? sel_we : 4'd0;
        dmem_addr = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
        dmem_din  = any_gnt ? sel_wdata : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (aux_gnt || !aux_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_d    = 3'b000;
        pend_d[2] = core_gnt & (core_we == 4'd0);
        pend_d[1] = aux_gnt & (aux_we == 4'd0);
        pend_d[0] = (pend_d[2] | pend_d[1]) & sel_oor;
    end

    always_comb begin
        core_rvalid = pend_q[2];
        aux_rvalid  = pend_q[1];
        core_rdata  = 32'd0;
        aux_rdata   = 32'd0;
        if (pend_q[2] && !pend_q[0]) begin
            core_rdata = dmem_dout;
        end
        if (pend_q[1] && !pend_q[0]) begin
            aux_rdata = dmem_dout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector-table and scoreboard bench for dmem_arbiter with a
// behavioural byte-enabled DMEM attached.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req;
    logic [3:0]        core_we;
    logic [31:0]       core_addr;
    logic [31:0]       core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;
    logic              aux_req;
    logic [3:0]        aux_we;
    logic [31:0]       aux_addr;
    logic [31:0]       aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [31:0]       aux_rdata;
    logic              dmem_en;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_din;
    logic [31:0]       dmem_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .aux_req(aux_req), .aux_we(aux_we),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout)
    );

    // Read-first synchronous memory model
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
        dmem_dout = 32'd0;
    end
    always @(posedge clk) begin
        if (dmem_en) begin
            dmem_dout <= mem[dmem_addr];
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
        end
    end

    typedef struct {
        logic        creq;
        logic [3:0]  cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        areq;
        logic [3:0]  awe;
        logic [31:0] aaddr;
        logic [31:0] awdata;
        logic        cg;
        logic        ag;
    } vec_t;

    typedef struct {
        logic        cv;
        logic        av;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        sb[$];
    logic [31:0] ref_mem [int];

    function automatic vec_t mk(
        input logic creq, input logic [3:0] cwe,
        input logic [31:0] caddr, input logic [31:0] cwdata,
        input logic areq, input logic [3:0] awe,
        input logic [31:0] aaddr, input logic [31:0] awdata,
        input logic cg, input logic ag);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.areq = areq; v.awe = awe; v.aaddr = aaddr; v.awdata = awdata;
        v.cg = cg; v.ag = ag;
        return v;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int idx = int'(a[ADDR_W+1:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    endfunction

    function automatic logic is_oor(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        core_req = v.creq; core_we = v.cwe;
        core_addr = v.caddr; core_wdata = v.cwdata;
        aux_req = v.areq; aux_we = v.awe;
        aux_addr = v.aaddr; aux_wdata = v.awdata;
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got no entry expected one");
            return;
        end
        e = sb.pop_front();
        chk("core_rvalid", 32'(core_rvalid), 32'(e.cv));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(e.av));
        chk("core_rdata", core_rdata, e.cv ? e.data : 32'd0);
        chk("aux_rdata", aux_rdata, e.av ? e.data : 32'd0);
    endtask

    task automatic step(input vec_t v);
        rsp_t        r;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        oor;
        logic        en;
        int          idx;
        @(negedge clk);
        drive(v);
        #1;
        check_rsp();
        chk("core_gnt", 32'(core_gnt), 32'(v.cg));
        chk("aux_gnt", 32'(aux_gnt), 32'(v.ag));
        chk("core_stall", 32'(core_stall), 32'(v.creq & ~v.cg));
        we  = v.ag ? v.awe : v.cwe;
        a   = v.ag ? v.aaddr : v.caddr;
        wd  = v.ag ? v.awdata : v.cwdata;
        oor = is_oor(a);
        en  = (v.cg | v.ag) & ~oor;
        chk("dmem_en", 32'(dmem_en), 32'(en));
        chk("dmem_we", 32'(dmem_we), en ? 32'(we) : 32'd0);
        if (en) begin
            chk("dmem_addr", 32'(dmem_addr), 32'(a[ADDR_W+1:2]));
            if (we != 4'd0) chk("dmem_din", dmem_din, wd);
        end
        r.cv = v.cg & (we == 4'd0);
        r.av = v.ag & (we == 4'd0);
        r.data = oor ? 32'd0 : ref_rd(a);
        sb.push_back(r);
        if (en && we != 4'd0) begin
            idx = int'(a[ADDR_W+1:2]);
            ref_mem[idx] = ref_rd(a);
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    function automatic void push_empty();
        rsp_t r;
        r.cv = 1'b0; r.av = 1'b0; r.data = 32'd0;
        sb.push_back(r);
    endfunction

    initial begin
        vec_t v;
        reset = 1'b0;
        v = mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0, 0, 0);
        drive(v);

        // Held in reset with both requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_core_gnt", 32'(core_gnt), 32'd0);
            chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
            chk("rst_dmem_en", 32'(dmem_en), 32'd0);
            chk("rst_dmem_we", 32'(dmem_we), 32'd0);
            chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
            chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
        end
        v = mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        drive(v);
        @(negedge clk);
        reset = 1'b1;
        push_empty();

        vecs.push_back(mk(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h20, 32'h12345678, 0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h20, 32'h0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0001_0000, 32'h0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h0001_0020, 32'hBADBAD00, 0, 1));
        vecs.push_back(mk(1, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 4'h3, 32'h13, 32'h0000CAFE, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        // Contention: both reading continuously
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0,
                              (i % 5) != 4, (i % 5) == 4));
        // Aux drops after two denials, then must wait four more
        vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0, 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h20, 32'h0, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0,
                              i != 4, i == 4));
        vecs.push_back(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Reset pulse in the cycle after a granted core read
        step(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("midrst_core_rdata", core_rdata, 32'd0);
        chk("midrst_core_gnt", 32'(core_gnt), 32'd0);
        chk("midrst_dmem_en", 32'(dmem_en), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        v = mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        drive(v);
        #1;
        chk("postrst_core_rvalid", 32'(core_rvalid), 32'd0);
        push_empty();
        step(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        step(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
